// File: rtl/seq_det_pkg.sv
// seq_det_pkg
// Shared definitions for the parametrised serial sequence detector.
//   state_e     : detector state encoding (FILL = window not yet complete,
//                 ARMED = window holds N valid bits)
//   MODE_NONOVL / MODE_OVL : values of the ovl input
package seq_det_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    ARMED = 1'b1
  } state_e;

  localparam logic MODE_NONOVL = 1'b0;
  localparam logic MODE_OVL    = 1'b1;

endpackage

// File: rtl/seq_shift_win.sv
// seq_shift_win
// N-bit enable-gated serial shift window. New bits enter at the MSB, so
// q_o[N-1] is the newest bit and q_o[0] the oldest.
// Ports:
//   clk_i    : clock, rising edge
//   clr_i    : synchronous active-high clear of the window
//   en_i     : shift strobe; d_i is taken only when high
//   d_i      : serial data bit
//   q_next_o : window contents after this edge (combinational look-ahead)
//   q_o      : registered window
module seq_shift_win
  import seq_det_pkg::*;
#(
  parameter int N = 6
) (
  input  logic         clk_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic         d_i,
  output logic [N-1:0] q_next_o,
  output logic [N-1:0] q_o
);

  logic [N-1:0] win_q;
  logic [N-1:0] win_d;

  always_comb begin
    win_d = win_q;
    if (en_i) win_d = {d_i, win_q[N-1:1]};
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) win_q <= '0;
    else       win_q <= win_d;
  end

  assign q_next_o = win_d;
  assign q_o      = win_q;

endmodule

// File: rtl/seq_det_param.sv
// seq_det_param
// Parametrised serial sequence detector. One bit is shifted into an N-bit
// window per en strobe and the look-ahead window is compared with the
// runtime pattern; a match gives a registered one-cycle flag pulse and bumps
// a saturating match counter. Matches are suppressed until N bits have been
// collected, and in non-overlapping mode N fresh bits are needed after each
// match.
// Optional build macro: SEQ_DET_MASK_EN adds a mask input whose set bits are
// don't-care positions in the compare.
// Ports:
//   clk       : clock, rising edge
//   r         : synchronous active-high reset
//   en        : bit-valid strobe
//   d         : serial data bit
//   pat       : pattern, pat[0] earliest bit in time
//   ovl       : 1 = overlapping detection, 0 = non-overlapping
//   clr_cnt   : synchronous clear of match_cnt
//   mask      : (SEQ_DET_MASK_EN only) don't-care bit positions
//   q         : window, q[N-1] newest, q[0] oldest
//   flag      : registered match pulse
//   match_cnt : saturating count of matches
//   cnt_sat   : high while match_cnt is all-ones
module seq_det_param
  import seq_det_pkg::*;
#(
  parameter int N     = 6,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             r,
  input  logic             en,
  input  logic             d,
  input  logic [N-1:0]     pat,
  input  logic             ovl,
  input  logic             clr_cnt,
`ifdef SEQ_DET_MASK_EN
  input  logic [N-1:0]     mask,
`endif
  output logic [N-1:0]     q,
  output logic             flag,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int                FILL_W    = $clog2(N + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(N);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic [N-1:0]      q_next;
  logic [FILL_W-1:0] fill_q, fill_d, fill_inc;
  state_e            state_q, state_d;
  logic              flag_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sat_q, sat_d;
  logic              win_eq;
  logic              hit;

  seq_shift_win #(.N(N)) u_win (
    .clk_i    (clk),
    .clr_i    (r),
    .en_i     (en),
    .d_i      (d),
    .q_next_o (q_next),
    .q_o      (q)
  );

  // Compare the window as it will look after this edge, so the flag lands
  // in the same cycle that q first shows the completed window.
`ifdef SEQ_DET_MASK_EN
  assign win_eq = (((q_next ^ pat) & ~mask) == '0);
`else
  assign win_eq = (q_next == pat);
`endif

  always_comb begin
    fill_inc = fill_q;
    if (en && (fill_q != FILL_FULL)) fill_inc = fill_q + FILL_W'(1);
  end

  assign hit = en && win_eq && (fill_inc == FILL_FULL);

  // Next-state: FILL arms once the N-th bit arrives; a non-overlapping match
  // restarts collection while leaving the window contents in place.
  always_comb begin
    state_d = state_q;
    fill_d  = fill_inc;
    case (state_q)
      FILL:    if (fill_inc == FILL_FULL) state_d = ARMED;
      ARMED:   state_d = ARMED;
      default: state_d = FILL;
    endcase
    if (hit && (ovl == MODE_NONOVL)) begin
      state_d = FILL;
      fill_d  = '0;
    end
  end

  // A clear coinciding with a match still counts that match.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt)                        cnt_d = hit ? CNT_W'(1) : '0;
    else if (hit && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_W'(1);
    sat_d = (cnt_d == CNT_MAX);
  end

  always_ff @(posedge clk) begin
    if (r) begin
      state_q <= FILL;
      fill_q  <= '0;
      flag_q  <= 1'b0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      flag_q  <= hit;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

  assign flag      = flag_q;
  assign match_cnt = cnt_q;
  assign cnt_sat   = sat_q;

endmodule

// File: doc/seq_det_param.md
Name: seq_det_param

Overview:
- Parametrised serial sequence detector, successor to the fixed 6-bit shift-register detector.
- Shifts in one bit per qualified clock into an N-bit window and compares the window against a runtime pattern input.
- Emits a registered match pulse and keeps a saturating match count.
- Supports overlapping or non-overlapping detection, suppresses false matches until the window is filled, and accepts bits only on an enable strobe.

Parameters:
N, 6, window/pattern length in bits (N >= 2)
CNT_W, 8, match counter width (CNT_W >= 1)

Ports:
clk  input  1  single clock, all state on rising edge
r  input  1  reset, synchronous, active-high
en  input  1  bit-valid strobe; d is sampled only when en=1
d  input  1  serial data bit
pat  input  N  target pattern; pat[0] is the earliest bit in time, pat[N-1] the latest
ovl  input  1  1 = overlapping detection, 0 = non-overlapping
clr_cnt  input  1  synchronous clear of match_cnt
q  output  N  window; q[N-1] newest bit, q[0] oldest
flag  output  1  registered one-cycle match pulse
match_cnt  output  CNT_W  saturating count of flag pulses
cnt_sat  output  1  high while match_cnt is at all-ones

Behaviour:
- Reset: one clock; synchronous, active-high (r). On an edge with r=1:
  - q=0, flag=0, match_cnt=0, cnt_sat=0, fill=0, state=FILL.
  - r overrides all other inputs.
- Shift: on an edge with en=1, q_next = {d, q[N-1:1]}. With en=0, q holds and flag is driven 0 at that edge.
- Fill counter: fill (0..N) increments on each en edge, saturating at N.
- State machine:
  - FILL: fill < N after the current shift. No match is possible.
  - ARMED: fill = N.
  - FILL -> ARMED when the N-th bit is shifted in.
  - ARMED -> FILL on a match when ovl=0 (fill forced to 0; q keeps its contents).
  - ARMED stays ARMED on a match when ovl=1.
- Match: hit = en & (q_next == pat) & (fill_next == N), evaluated at the same edge that shifts the completing bit. flag <= hit.
  - flag is high during the cycle following the completing edge, concurrent with q showing the full window.
- Overlap: with ovl=1, consecutive matching windows give flag high on consecutive en cycles. pat=all-ones with continuous ones gives flag held high.
- Non-overlap: after a match, the next match needs N fresh en bits.
- pat and ovl are not registered. A change takes effect at the next comparison edge.
- Counter:
  - On an edge with hit=1, match_cnt increments, saturating at 2^CNT_W-1.
  - cnt_sat = (match_cnt == all-ones), registered alongside match_cnt.
  - clr_cnt and hit on the same edge: match_cnt=1.
  - clr_cnt alone: match_cnt=0.
- Reset mid-sequence discards the partial window. The next match needs N bits after reset deasserts.

Optional Feature:
- Macro SEQ_DET_MASK_EN.
- Defined: adds input port mask[N-1:0]. Bit positions with mask[i]=1 are don't-care. Compare is ((q_next ^ pat) & ~mask) == 0. mask=0 behaves exactly as the non-masked build.
- Undefined: no mask port; exact compare.

Decomposition:
- Package seq_det_pkg holds:
  - state encoding constants FILL=1'b0, ARMED=1'b1
  - ovl mode constants MODE_NONOVL=1'b0, MODE_OVL=1'b1
- One sub-module, seq_shift_win: N-bit enable-gated shift window with synchronous active-high clear, outputting q_next and q.
- Match compare, fill/state logic and counter stay in seq_det_param.

Test Plan:
1. N=6, pat=6'b110101, ovl=1, en=1, d=1,0,1,0,1,1 after reset -> flag=1 only in the cycle after the 6th edge; q=6'b110101; match_cnt=1.
2. pat=6'b000000, d=0 continuously after reset -> no flag for the first 5 edges; flag first rises after the 6th edge, then stays high with ovl=1.
3. pat=6'b111111, eight consecutive 1s:
   - ovl=1 -> flag high 3 consecutive cycles, match_cnt=3.
   - ovl=0 -> single flag after bit 6, match_cnt=1.
4. Pattern 1,0,1,0,1,1 fed with en=0 gap cycles between bits -> same single flag after the last en edge; flag=0 on gap cycles.
5. CNT_W=2, 5 matches -> match_cnt=3, cnt_sat=1. Then clr_cnt=1 coincident with a match -> match_cnt=1, cnt_sat=0.
6. Five pattern bits, r=1 for one cycle, then the 6th bit -> no flag, q=6'b100000 (only the new bit present), fill=1.
